// File: rtl/piso_bit_serializer.sv
// Parallel-in, serial-out stage: accepts WIDTH-bit words over valid/ready and
// shifts them out one bit per clock, MSB- or LSB-first, with an optional idle gap.
module piso_bit_serializer #(
    parameter int   WIDTH    = 8,
    parameter int   GAP      = 0,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             msb_first,
    output logic             ser_out,
    output logic             ser_active,
    output logic             frame_done
);

    localparam int                CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(WIDTH - 2);
    localparam logic [3:0]        GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);
    localparam bit                HAS_GAP  = (GAP > 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_d;
    logic [3:0]       gap_cnt, gap_cnt_d;
    logic [WIDTH-1:0] sreg, sreg_d;
    logic             ser_out_d, ser_active_d, frame_done_d;
    logic             last_bit, gap_last, accept;
    logic [WIDTH-1:0] load_word;

    // The shift register always holds remaining bits MSB-aligned; LSB-first
    // words are bit-reversed once at accept so the shift direction is fixed.
    function automatic logic [WIDTH-1:0] to_msb_order(input logic [WIDTH-1:0] w,
                                                      input logic msb);
        logic [WIDTH-1:0] r;
        r = w;
        if (!msb) begin
            for (int i = 0; i < WIDTH; i++) r[i] = w[WIDTH-1-i];
        end
        return r;
    endfunction

    assign last_bit   = (bit_cnt == LAST_BIT);
    assign gap_last   = HAS_GAP && (gap_cnt == GAP_LAST);
    assign data_ready = (state == S_IDLE)
                     || ((state == S_SHIFT) && last_bit && !HAS_GAP)
                     || ((state == S_GAP) && gap_last);
    assign accept     = data_valid && data_ready;
    assign load_word  = to_msb_order(data_in, msb_first);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_d      = state;
        bit_cnt_d    = bit_cnt;
        gap_cnt_d    = gap_cnt;
        sreg_d       = sreg;
        ser_out_d    = IDLE_BIT;
        ser_active_d = 1'b0;
        frame_done_d = 1'b0;

        unique case (state)
            S_IDLE: ;
            S_SHIFT: begin
                if (!last_bit) begin
                    ser_out_d    = sreg[WIDTH-1];
                    sreg_d       = sreg << 1;
                    bit_cnt_d    = bit_cnt + 1'b1;
                    ser_active_d = 1'b1;
                    frame_done_d = (bit_cnt == PRE_LAST);
                end else if (HAS_GAP) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_last) state_d = S_IDLE;
                else          gap_cnt_d = gap_cnt + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // An accept overrides whatever the current state planned next.
        if (accept) begin
            state_d      = S_SHIFT;
            bit_cnt_d    = '0;
            gap_cnt_d    = '0;
            ser_out_d    = load_word[WIDTH-1];
            sreg_d       = load_word << 1;
            ser_active_d = 1'b1;
            frame_done_d = 1'b0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            // NOTE: the word register is reset too, so a word cut off by reset
            // can never reappear on ser_out afterwards.
            sreg       <= '0;
            ser_out    <= IDLE_BIT;
            ser_active <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            bit_cnt    <= bit_cnt_d;
            gap_cnt    <= gap_cnt_d;
            sreg       <= sreg_d;
            ser_out    <= ser_out_d;
            ser_active <= ser_active_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Bench for piso_bit_serializer: two instances (GAP=0/IDLE_BIT=0 and GAP=2/IDLE_BIT=1)
// checked every cycle against a schedule-based model, plus directed literal cases.
module tb_piso_bit_serializer;

    localparam int W = 8;

    logic            clk;
    logic            rst;
    logic [1:0][7:0] din;
    logic [1:0]      vld, msb, rdy, so, sa, fd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: expected serial bit per (instance, cycle); absent key = idle cycle.
    bit exp_bit[int];
    bit exp_done[int];
    int next_free[2] = '{0, 0};

    logic [3:0] hist = '0;
    int det_cnt = 0;

    piso_bit_serializer #(.WIDTH(W), .GAP(0), .IDLE_BIT(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .data_in(din[0]), .data_valid(vld[0]),
        .data_ready(rdy[0]), .msb_first(msb[0]), .ser_out(so[0]),
        .ser_active(sa[0]), .frame_done(fd[0])
    );

    piso_bit_serializer #(.WIDTH(W), .GAP(2), .IDLE_BIT(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(din[1]), .data_valid(vld[1]),
        .data_ready(rdy[1]), .msb_first(msb[1]), .ser_out(so[1]),
        .ser_active(sa[1]), .frame_done(fd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int gap_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic logic idle_of(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // 1011 detector watching instance 0's serial stream.
    always @(negedge clk) begin
        if (rst) begin
            hist <= '0;
        end else begin
            hist <= {hist[2:0], so[0]};
            if ({hist[2:0], so[0]} == 4'b1011) det_cnt <= det_cnt + 1;
        end
    end

    // Compare process: checks every cycle, then books any accept the model predicts.
    always @(negedge clk) begin
        if (rst) begin
            exp_bit.delete();
            exp_done.delete();
            next_free[0] = 0;
            next_free[1] = 0;
        end
        for (int i = 0; i < 2; i++) begin
            int         key;
            logic       ea, eb, ed, er;
            logic [7:0] w;
            key = i * 1000000 + cyc;
            ea  = (exp_bit.exists(key) != 0);
            eb  = ea ? exp_bit[key] : idle_of(i);
            ed  = ea && exp_done[key];
            er  = rst || (cyc + 1 >= next_free[i]);
            check($sformatf("ser_out%0d@%0d", i, cyc),    32'(so[i]),  32'(eb));
            check($sformatf("ser_active%0d@%0d", i, cyc), 32'(sa[i]),  32'(ea));
            check($sformatf("frame_done%0d@%0d", i, cyc), 32'(fd[i]),  32'(ed));
            check($sformatf("data_ready%0d@%0d", i, cyc), 32'(rdy[i]), 32'(er));
            if (!rst && vld[i] && er) begin
                w = din[i];
                for (int j = 0; j < W; j++) begin
                    exp_bit[i * 1000000 + cyc + 1 + j]  = msb[i] ? w[W-1-j] : w[j];
                    exp_done[i * 1000000 + cyc + 1 + j] = (j == W - 1);
                end
                next_free[i] = cyc + 1 + W + gap_of(i);
            end
        end
    end

    task automatic send(input int inst, input logic [7:0] w, input logic m);
        int n;
        @(posedge clk); #1;
        din[inst] = w;
        vld[inst] = 1'b1;
        msb[inst] = m;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[inst] && n < 50);
        check("send_timeout", 32'(rdy[inst]), 32'd1);
        @(posedge clk); #1;
        vld[inst] = 1'b0;
    endtask

    // Collects n cycles of outputs, first cycle in the most significant position.
    task automatic collect(input int inst, input int n, output logic [31:0] sov,
                           output logic [31:0] sav, output logic [31:0] rdv,
                           output logic [31:0] fdv);
        sov = '0; sav = '0; rdv = '0; fdv = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sov = {sov[30:0], so[inst]};
            sav = {sav[30:0], sa[inst]};
            rdv = {rdv[30:0], rdy[inst]};
            fdv = {fdv[30:0], fd[inst]};
        end
    endtask

    initial begin
        logic [31:0] sov, sav, rdv, fdv;
        int d0;

        rst = 1'b1;
        vld = '0;
        msb = '0;
        din = '0;
        @(posedge clk); #1;
        check("rst_ser_out0", 32'(so[0]), 32'd0);
        check("rst_ser_out1", 32'(so[1]), 32'd1);
        check("rst_active",   32'(sa),    32'd0);
        check("rst_done",     32'(fd),    32'd0);
        check("rst_ready",    32'(rdy),   32'd3);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 1: MSB-first 0xB0
        send(0, 8'hB0, 1'b1);
        collect(0, 8, sov, sav, rdv, fdv);
        check("t1_bits",   sov, 32'hB0);
        check("t1_active", sav, 32'hFF);
        check("t1_done",   fdv, 32'h01);
        @(negedge clk);
        check("t1_after_out",   32'(so[0]),  32'd0);
        check("t1_after_ready", 32'(rdy[0]), 32'd1);

        // 2: LSB-first 0x0D gives 1,0,1,1,0,0,0,0
        repeat (3) @(posedge clk);
        d0 = det_cnt;
        send(0, 8'h0D, 1'b0);
        collect(0, 8, sov, sav, rdv, fdv);
        check("t2_bits", sov, 32'hB0);
        @(posedge clk); #1;
        check("t2_detect", 32'(det_cnt - d0), 32'd1);

        // 3: gapless back-to-back 0x01, 0x60 with valid held high
        repeat (3) @(posedge clk);
        d0 = det_cnt;
        @(posedge clk); #1;
        din[0] = 8'h01; vld[0] = 1'b1; msb[0] = 1'b1;
        @(posedge clk); #1;
        din[0] = 8'h60;
        fork
            collect(0, 16, sov, sav, rdv, fdv);
            begin
                repeat (8) @(posedge clk);
                #1 vld[0] = 1'b0;
            end
        join
        check("t3_bits",   sov, 32'h0160);
        check("t3_active", sav, 32'hFFFF);
        check("t3_ready",  rdv, 32'h0101);
        check("t3_done",   fdv, 32'h0101);
        @(posedge clk); #1;
        check("t3_detect", 32'(det_cnt - d0), 32'd1);

        // 4: GAP=2 instance, two words with valid held high
        @(posedge clk); #1;
        din[1] = 8'hC3; vld[1] = 1'b1; msb[1] = 1'b1;
        @(posedge clk); #1;
        din[1] = 8'h5A;
        fork
            collect(1, 18, sov, sav, rdv, fdv);
            begin
                repeat (10) @(posedge clk);
                #1 vld[1] = 1'b0;
            end
        join
        check("t4_bits",   sov, {14'd0, 8'hC3, 2'b11, 8'h5A});
        check("t4_active", sav, {14'd0, 8'hFF, 2'b00, 8'hFF});
        check("t4_ready",  rdv, {14'd0, 8'h00, 2'b01, 8'h00});

        // 5: data_in churns while shifting; captured word must survive
        repeat (4) @(posedge clk);
        @(posedge clk); #1;
        din[0] = 8'h35; vld[0] = 1'b1; msb[0] = 1'b0;
        @(posedge clk); #1;
        fork
            collect(0, 8, sov, sav, rdv, fdv);
            for (int i = 1; i <= 7; i++) begin
                @(posedge clk); #1;
                din[0] = 8'($urandom);
                if (i == 7) vld[0] = 1'b0;
            end
        join
        check("t5_bits",  sov, 32'hAC);
        check("t5_ready", rdv, 32'h01);

        // 6: asynchronous reset during bit 3, then a clean word
        repeat (3) @(posedge clk);
        send(0, 8'hFF, 1'b1);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t6_rst_out",    32'(so[0]),  32'd0);
        check("t6_rst_active", 32'(sa[0]),  32'd0);
        check("t6_rst_ready",  32'(rdy[0]), 32'd1);
        check("t6_rst_done",   32'(fd[0]),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        send(0, 8'hA5, 1'b1);
        collect(0, 8, sov, sav, rdv, fdv);
        check("t6_bits", sov, 32'hA5);

        // Randomized traffic on both instances
        repeat (600) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                vld[i] = ($urandom_range(0, 3) != 0);
                din[i] = 8'($urandom);
                msb[i] = 1'($urandom);
            end
        end
        @(posedge clk); #1;
        vld = '0;
        repeat (40) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
